// File: rtl/cache_axi_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_axi_arbiter_if
//  Single-beat AXI3 bus between the cache arbiter and the memory side.
//  Only the fields the arbiter drives or consumes are carried. Burst, lock,
//  cache and prot fields are constant and are tied where the bus leaves the
//  core.
//
//  Signal groups
//   AR : arid[3:0], araddr[31:0], arsize[2:0], arvalid  -> ; arready <-
//   R  : rdata[31:0], rvalid <- ; rready ->
//   AW : awid[3:0], awaddr[31:0], awsize[2:0], awvalid  -> ; awready <-
//   W  : wdata[31:0], wstrb[3:0], wlast, wvalid -> ; wready <-
//   B  : bvalid <- ; bready ->
//  ("->" is driven by the master modport, "<-" by the slave modport.)
// -----------------------------------------------------------------------------
interface cache_axi_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arsize, arvalid,
    input  arready,
    input  rdata, rvalid,
    output rready,
    output awid, awaddr, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arsize, arvalid,
    output arready,
    output rdata, rvalid,
    input  rready,
    input  awid, awaddr, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/cache_axi_arbiter.sv
// -----------------------------------------------------------------------------
// cache_axi_arbiter
//  Merges the instruction-cache and data-cache SRAM-like request ports onto a
//  single AXI3 master, one single-beat transaction at a time. The data cache
//  has fixed priority over the instruction cache.
//
//  Ports
//   clk, resetn                 clock, synchronous active-low reset
//   inst_req, inst_addr         icache read request (held until inst_aok)
//   inst_rdata                  icache read data, valid with inst_dok, held
//   inst_aok, inst_dok          1-cycle pulses: address accepted / data back
//   data_req, data_wen,
//   data_addr, data_wdata       dcache request; wen == 0 means read
//   data_rdata                  dcache read data, valid with data_dok, held
//   data_aok, data_dok          1-cycle pulses: request accepted / completed
//   axi                         AXI3 master (AR, R, AW, W, B channels)
//
//  Parameters
//   INST_ID / DATA_ID           AXI id used for icache / dcache transactions
// -----------------------------------------------------------------------------
module cache_axi_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic                       clk,
  input  logic                       resetn,

  input  logic                       inst_req,
  input  logic [31:0]                inst_addr,
  output logic [31:0]                inst_rdata,
  output logic                       inst_aok,
  output logic                       inst_dok,

  input  logic                       data_req,
  input  logic [3:0]                 data_wen,
  input  logic [31:0]                data_addr,
  input  logic [31:0]                data_wdata,
  output logic [31:0]                data_rdata,
  output logic                       data_aok,
  output logic                       data_dok,

  cache_axi_arbiter_if.master        axi
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic        grant_data_r;   // 1: current transaction belongs to the dcache
  logic [31:0] addr_r;
  logic [3:0]  wen_r;
  logic [31:0] wdata_r;
  logic        aw_done_r;
  logic        w_done_r;

  logic        arvalid_s;
  logic        rready_s;
  logic        awvalid_s;
  logic        wvalid_s;
  logic        bready_s;
  logic        aw_hs_s;
  logic        w_hs_s;

  // AXI size from the byte-enable pattern; irregular patterns fall back to a
  // full word and rely on wstrb to mask the bytes.
  function automatic logic [2:0] size_from_wen(input logic [3:0] wen);
    logic [2:0] size;
    case (wen)
      4'b1111:                            size = 3'd2;
      4'b0011, 4'b1100:                   size = 3'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 3'd0;
      default:                            size = 3'd2;
    endcase
    return size;
  endfunction

  // Transaction state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode, channel valid/ready and aok/dok pulse generation
  always_comb begin
    state_next_s = state_r;
    arvalid_s    = 1'b0;
    rready_s     = 1'b0;
    awvalid_s    = 1'b0;
    wvalid_s     = 1'b0;
    bready_s     = 1'b0;
    aw_hs_s      = 1'b0;
    w_hs_s       = 1'b0;
    inst_aok     = 1'b0;
    inst_dok     = 1'b0;
    data_aok     = 1'b0;
    data_dok     = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (data_req) begin
          if (data_wen != 4'b0000) begin
            state_next_s = S_AW_W;
          end else begin
            state_next_s = S_AR;
          end
        end else if (inst_req) begin
          state_next_s = S_AR;
        end else begin
          state_next_s = S_IDLE;
        end
      end

      S_AR: begin
        arvalid_s = 1'b1;
        if (axi.arready) begin
          if (grant_data_r) begin
            data_aok = 1'b1;
          end else begin
            inst_aok = 1'b1;
          end
          state_next_s = S_R;
        end else begin
          state_next_s = S_AR;
        end
      end

      S_R: begin
        rready_s = 1'b1;
        if (axi.rvalid) begin
          state_next_s = S_RESP;
        end else begin
          state_next_s = S_R;
        end
      end

      // AW and W complete independently; the request is only accepted once
      // both channels have handshaken, counting a handshake in this cycle.
      S_AW_W: begin
        awvalid_s = !aw_done_r;
        wvalid_s  = !w_done_r;
        aw_hs_s   = awvalid_s & axi.awready;
        w_hs_s    = wvalid_s & axi.wready;
        if ((aw_done_r | aw_hs_s) && (w_done_r | w_hs_s)) begin
          data_aok     = 1'b1;
          state_next_s = S_B;
        end else begin
          state_next_s = S_AW_W;
        end
      end

      S_B: begin
        bready_s = 1'b1;
        if (axi.bvalid) begin
          state_next_s = S_RESP;
        end else begin
          state_next_s = S_B;
        end
      end

      S_RESP: begin
        if (grant_data_r) begin
          data_dok = 1'b1;
        end else begin
          inst_dok = 1'b1;
        end
        state_next_s = S_IDLE;
      end

      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Request capture, write-handshake bookkeeping and read-data return
  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant_data_r <= 1'b0;
      addr_r       <= 32'h0000_0000;
      wen_r        <= 4'b0000;
      wdata_r      <= 32'h0000_0000;
      aw_done_r    <= 1'b0;
      w_done_r     <= 1'b0;
      inst_rdata   <= 32'h0000_0000;
      data_rdata   <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
          if (data_req) begin
            grant_data_r <= 1'b1;
            addr_r       <= data_addr;
            wen_r        <= data_wen;
            wdata_r      <= data_wdata;
          end else if (inst_req) begin
            grant_data_r <= 1'b0;
            addr_r       <= inst_addr;
            wen_r        <= 4'b0000;
            wdata_r      <= 32'h0000_0000;
          end else begin
            grant_data_r <= grant_data_r;
          end
        end

        S_AW_W: begin
          aw_done_r <= aw_done_r | aw_hs_s;
          w_done_r  <= w_done_r | w_hs_s;
        end

        // Only the granted master's read-data register is ever written.
        S_R: begin
          if (axi.rvalid) begin
            if (grant_data_r) begin
              data_rdata <= axi.rdata;
            end else begin
              inst_rdata <= axi.rdata;
            end
          end else begin
            data_rdata <= data_rdata;
          end
        end

        default: begin
          aw_done_r <= aw_done_r;
        end
      endcase
    end
  end

  assign axi.arid    = grant_data_r ? DATA_ID : INST_ID;
  assign axi.araddr  = addr_r;
  assign axi.arsize  = 3'd2;
  assign axi.arvalid = arvalid_s;
  assign axi.rready  = rready_s;

  assign axi.awid    = grant_data_r ? DATA_ID : INST_ID;
  assign axi.awaddr  = addr_r;
  assign axi.awsize  = size_from_wen(wen_r);
  assign axi.awvalid = awvalid_s;

  assign axi.wdata   = wdata_r;
  assign axi.wstrb   = wen_r;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_s;

  assign axi.bready  = bready_s;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
module tb_cache_axi_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_aok;
  logic        inst_dok;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_aok;
  logic        data_dok;

  always #5 clk = ~clk;

  cache_axi_arbiter_if bus();

  cache_axi_arbiter #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_aok   (inst_aok),
    .inst_dok   (inst_dok),
    .data_req   (data_req),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_aok   (data_aok),
    .data_dok   (data_dok),
    .axi        (bus)
  );

  // Expected transaction, in grant order
  typedef struct {
    logic        is_data;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  // Stimulus vector: request, slave response delays and expected AXI size
  typedef struct {
    logic        is_inst;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ar_dly;
    int          aw_dly;
    int          w_dly;
    int          r_dly;
    int          b_dly;
    logic [2:0]  exp_size;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];
  exp_t sb_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
  int ar_start_cyc = 0, aok_cyc = 0, last_dok_cyc = 0;
  logic [31:0] inst_model = 32'h0;
  logic [31:0] data_model = 32'h0;
  logic aw_seen = 1'b0, w_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // AXI slave: each ready/valid answers after a programmable number of cycles
  initial begin : slave
    int ar_c, aw_c, w_c, r_c, b_c;
    ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.arvalid) begin bus.arready = (ar_c >= ar_dly); ar_c++; end
      else begin bus.arready = 1'b0; ar_c = 0; end
      if (bus.awvalid) begin bus.awready = (aw_c >= aw_dly); aw_c++; end
      else begin bus.awready = 1'b0; aw_c = 0; end
      if (bus.wvalid) begin bus.wready = (w_c >= w_dly); w_c++; end
      else begin bus.wready = 1'b0; w_c = 0; end
      if (bus.rready) begin
        bus.rvalid = (r_c >= r_dly);
        bus.rdata  = (sb_q.size() > 0) ? sb_q[0].rdata : 32'h0;
        r_c++;
      end else begin
        bus.rvalid = 1'b0; bus.rdata = 32'h0; r_c = 0;
      end
      if (bus.bready) begin bus.bvalid = (b_c >= b_dly); b_c++; end
      else begin bus.bvalid = 1'b0; b_c = 0; end
    end
  end

  // Monitor: protocol rules, per-channel field checks and scoreboard pops
  initial begin : monitor
    logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_dok, have_e;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    exp_t e;
    p_arv = 1'b0; p_arr = 1'b0; p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0;
    p_dok = 1'b0; p_araddr = 32'h0; p_awaddr = 32'h0; p_wdata = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (!resetn) begin
        inst_model = 32'h0; data_model = 32'h0; aw_seen = 1'b0; w_seen = 1'b0;
        p_arv = 1'b0; p_arr = 1'b0; p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0;
        p_dok = 1'b0;
      end else begin
        have_e = (sb_q.size() > 0);
        if (have_e) e = sb_q[0];
        if (p_arv && !p_arr) begin
          chk("arvalid_held", 32'(bus.arvalid), 32'd1);
          chk("araddr_held", bus.araddr, p_araddr);
        end
        if (p_awv && !p_awr) begin
          chk("awvalid_held", 32'(bus.awvalid), 32'd1);
          chk("awaddr_held", bus.awaddr, p_awaddr);
        end
        if (p_wv && !p_wr) begin
          chk("wvalid_held", 32'(bus.wvalid), 32'd1);
          chk("wdata_held", bus.wdata, p_wdata);
        end
        if (aw_seen) chk("awvalid_dropped", 32'(bus.awvalid), 32'd0);
        if (w_seen)  chk("wvalid_dropped", 32'(bus.wvalid), 32'd0);
        if (bus.arvalid && !bus.arready) chk("no_aok_before_ar", 32'({inst_aok, data_aok}), 32'd0);
        if (bus.arvalid && !p_arv) begin
          ar_start_cyc = cyc;
          chk("ar_after_prev_dok", 32'(cyc > last_dok_cyc), 32'd1);
        end
        if (bus.arvalid && bus.arready) begin
          if (!have_e) fail_now("unexpected_ar");
          else begin
            chk("arid", 32'(bus.arid), e.is_data ? 32'd1 : 32'd0);
            chk("araddr", bus.araddr, e.addr);
            chk("arsize", 32'(bus.arsize), 32'd2);
            chk("ar_aok", 32'({inst_aok, data_aok}), e.is_data ? 32'd1 : 32'd2);
            aok_cyc = cyc;
          end
        end
        if (bus.awvalid && bus.awready) begin
          if (!have_e) fail_now("unexpected_aw");
          else begin
            chk("awid", 32'(bus.awid), 32'd1);
            chk("awaddr", bus.awaddr, e.addr);
            chk("awsize", 32'(bus.awsize), 32'(e.size));
          end
          aw_seen = 1'b1;
        end
        if (bus.wvalid && bus.wready) begin
          if (!have_e) fail_now("unexpected_w");
          else begin
            chk("wdata", bus.wdata, e.wdata);
            chk("wstrb", 32'(bus.wstrb), 32'(e.strb));
            chk("wlast", 32'(bus.wlast), 32'd1);
          end
          w_seen = 1'b1;
        end
        if (data_aok && have_e && e.is_write) begin
          chk("write_aok_after_aw_w", 32'(aw_seen & w_seen), 32'd1);
          aok_cyc = cyc;
        end
        if (inst_aok | data_aok | inst_dok | data_dok)
          chk("aok_dok_exclusive", 32'((inst_aok | data_aok) & (inst_dok | data_dok)), 32'd0);
        if (p_dok) chk("dok_one_cycle", 32'(inst_dok | data_dok), 32'd0);
        if (inst_dok || data_dok) begin
          if (!have_e) fail_now("unexpected_dok");
          else begin
            void'(sb_q.pop_front());
            chk("dok_master", 32'({inst_dok, data_dok}), e.is_data ? 32'd1 : 32'd2);
            if (!e.is_write) begin
              if (e.is_data) data_model = e.rdata;
              else inst_model = e.rdata;
            end
          end
          last_dok_cyc = cyc;
          aw_seen = 1'b0;
          w_seen  = 1'b0;
        end
        chk("inst_rdata", inst_rdata, inst_model);
        chk("data_rdata", data_rdata, data_model);
        p_arv = bus.arvalid; p_arr = bus.arready; p_araddr = bus.araddr;
        p_awv = bus.awvalid; p_awr = bus.awready; p_awaddr = bus.awaddr;
        p_wv  = bus.wvalid;  p_wr  = bus.wready;  p_wdata  = bus.wdata;
        p_dok = inst_dok | data_dok;
      end
    end
  end

  task automatic drive_data(input logic [3:0] wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic hold);
    logic got;
    got = 1'b0;
    data_req = 1'b1; data_wen = wen; data_addr = addr; data_wdata = wdata;
    for (int k = 0; k < 100 && !got; k++) begin
      #1;
      if (data_aok) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) fail_now("data_aok_timeout");
    if (!hold) begin
      data_req = 1'b0; data_wen = 4'b0000; data_addr = 32'h0; data_wdata = 32'h0;
    end
  endtask

  task automatic drive_inst(input logic [31:0] addr);
    logic got;
    got = 1'b0;
    inst_req = 1'b1; inst_addr = addr;
    for (int k = 0; k < 100 && !got; k++) begin
      #1;
      if (inst_aok) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) fail_now("inst_aok_timeout");
    inst_req = 1'b0; inst_addr = 32'h0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) step();
    if (sb_q.size() != 0) begin
      fail_now("drain_timeout");
      sb_q.delete();
    end
    step();
  endtask

  task automatic push_exp(input logic is_data, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input logic [2:0] size);
    exp_t e;
    e.is_data  = is_data;
    e.is_write = is_data && (wen != 4'b0000);
    e.addr     = addr;
    e.size     = size;
    e.strb     = wen;
    e.wdata    = wdata;
    e.rdata    = rdata;
    sb_q.push_back(e);
  endtask

  task automatic check_all_idle(input string tag);
    chk({tag, "_ctrl"}, 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
                             inst_aok, inst_dok, data_aok, data_dok}), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : test
    int n0;
    //              inst  wen      addr          wdata         rdata         ar aw w  r  b  size
    vecs[0]  = '{1'b0, 4'b0000, 32'h0000_1000, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 0, 3'd2};
    vecs[1]  = '{1'b1, 4'b0000, 32'h0000_0040, 32'h0,        32'h1357_9BDF, 0, 0, 0, 0, 0, 3'd2};
    vecs[2]  = '{1'b0, 4'b1111, 32'h0000_3000, 32'hCAFE_F00D, 32'h0,       0, 0, 0, 0, 0, 3'd2};
    vecs[3]  = '{1'b0, 4'b0011, 32'h0000_2002, 32'h0000_1234, 32'h0,       0, 3, 0, 0, 1, 3'd1};
    vecs[4]  = '{1'b0, 4'b1100, 32'h0000_2000, 32'hAABB_0000, 32'h0,       0, 0, 2, 0, 0, 3'd1};
    vecs[5]  = '{1'b0, 4'b0100, 32'h0000_2001, 32'h00CC_0000, 32'h0,       0, 1, 1, 0, 2, 3'd0};
    vecs[6]  = '{1'b0, 4'b1000, 32'h0000_2003, 32'hDD00_0000, 32'h0,       0, 0, 0, 0, 0, 3'd0};
    vecs[7]  = '{1'b0, 4'b0101, 32'h0000_2004, 32'h0011_0022, 32'h0,       0, 2, 0, 0, 0, 3'd2};
    vecs[8]  = '{1'b0, 4'b0111, 32'h0000_2008, 32'h0033_4455, 32'h0,       0, 0, 0, 0, 0, 3'd2};
    vecs[9]  = '{1'b0, 4'b0000, 32'h0000_4000, 32'h0,        32'h0BAD_F00D, 5, 0, 0, 2, 0, 3'd2};
    vecs[10] = '{1'b1, 4'b0000, 32'h0000_0080, 32'h0,        32'h1111_2222, 2, 0, 0, 3, 0, 3'd2};
    vecs[11] = '{1'b0, 4'b0001, 32'h0000_2000, 32'h0000_0077, 32'h0,       0, 0, 3, 0, 0, 3'd0};

    resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wen = 4'b0000; data_addr = 32'h0; data_wdata = 32'h0;
    repeat (3) step();
    #1;
    check_all_idle("reset");
    chk("reset_inst_rdata", inst_rdata, 32'h0);
    chk("reset_data_rdata", data_rdata, 32'h0);
    step();
    resetn = 1'b1;
    step();

    // First read: exact latency from request to arvalid, aok and dok
    n0 = cyc;
    push_exp(1'b1, 4'b0000, 32'h0000_1000, 32'h0, 32'hDEADBEEF, 3'd2);
    drive_data(4'b0000, 32'h0000_1000, 32'h0, 1'b0);
    wait_idle();
    chk("lat_arvalid", 32'(ar_start_cyc), 32'(n0 + 1));
    chk("lat_aok", 32'(aok_cyc), 32'(n0 + 1));
    chk("lat_dok", 32'(last_dok_cyc), 32'(n0 + 3));

    // Table of single transactions with varied slave delays
    for (int i = 0; i < NV; i++) begin
      ar_dly = vecs[i].ar_dly; aw_dly = vecs[i].aw_dly; w_dly = vecs[i].w_dly;
      r_dly  = vecs[i].r_dly;  b_dly  = vecs[i].b_dly;
      push_exp(!vecs[i].is_inst, vecs[i].wen, vecs[i].addr, vecs[i].wdata,
               vecs[i].rdata, vecs[i].exp_size);
      if (vecs[i].is_inst) drive_inst(vecs[i].addr);
      else drive_data(vecs[i].wen, vecs[i].addr, vecs[i].wdata, 1'b0);
      wait_idle();
    end
    ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 0; b_dly = 0;

    // Simultaneous requests: data first, instruction afterwards
    push_exp(1'b1, 4'b0000, 32'h0000_6000, 32'h0, 32'hAAAA_5555, 3'd2);
    push_exp(1'b0, 4'b0000, 32'h0000_0100, 32'h0, 32'h1234_5678, 3'd2);
    fork
      drive_data(4'b0000, 32'h0000_6000, 32'h0, 1'b0);
      drive_inst(32'h0000_0100);
    join
    wait_idle();
    chk("both_inst_rdata", inst_rdata, 32'h1234_5678);
    chk("both_data_rdata", data_rdata, 32'hAAAA_5555);

    // Back-to-back dcache reads with the request held continuously
    push_exp(1'b1, 4'b0000, 32'h0000_7000, 32'h0, 32'h7000_0001, 3'd2);
    push_exp(1'b1, 4'b0000, 32'h0000_7004, 32'h0, 32'h7000_0002, 3'd2);
    drive_data(4'b0000, 32'h0000_7000, 32'h0, 1'b1);
    drive_data(4'b0000, 32'h0000_7004, 32'h0, 1'b0);
    wait_idle();
    chk("b2b_data_rdata", data_rdata, 32'h7000_0002);

    // Reset while waiting for read data
    r_dly = 20;
    push_exp(1'b1, 4'b0000, 32'h0000_5000, 32'h0, 32'h5555_5555, 3'd2);
    drive_data(4'b0000, 32'h0000_5000, 32'h0, 1'b0);
    chk("in_r_rready", 32'(bus.rready), 32'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    sb_q.delete();
    r_dly = 0;
    #1;
    check_all_idle("midreset");
    chk("midreset_inst_rdata", inst_rdata, 32'h0);
    chk("midreset_data_rdata", data_rdata, 32'h0);
    step();

    // Recovery after the abort
    push_exp(1'b1, 4'b0000, 32'h0000_5004, 32'h0, 32'h0F0F_0F0F, 3'd2);
    drive_data(4'b0000, 32'h0000_5004, 32'h0, 1'b0);
    wait_idle();
    chk("recover_data_rdata", data_rdata, 32'h0F0F_0F0F);

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
